// File: rtl/sync_fifo_param_pkg.sv
// ----------------------------------------------------------------------------
// sync_fifo_param_pkg
// Shared helpers for the parametrised synchronous FIFO.
//   clog2         : constant function, ceiling log2, usable in parameter context
//   DEF_WIDTH ..  : default parameter values used by the FIFO and its interface
// Pointer width is clog2(DEPTH) and count width is clog2(DEPTH+1); both are
// derived per instance from these helpers since a package cannot be
// parameterised.
// ----------------------------------------------------------------------------
package sync_fifo_param_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_DEPTH    = 8;
   localparam int DEF_AF_LEVEL = 6;
   localparam int DEF_AE_LEVEL = 2;

   // Smallest r with 2**r >= value; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_param_if
// Handshake/status bundle of the synchronous FIFO (clk/rst stay plain ports).
//   master : the producer/consumer side (drives flush, clr_err, wr, wr_data, rd)
//   slave  : the FIFO itself (drives rd_data, rd_valid, count and all flags)
// Signals
//   flush, clr_err, wr, rd      1 bit requests
//   wr_data, rd_data            WIDTH bits
//   rd_valid                    rd_data holds a valid word
//   count                       clog2(DEPTH+1) bits, 0..DEPTH
//   full, empty, almost_full, almost_empty, overflow, underflow   1 bit flags
// ----------------------------------------------------------------------------
interface sync_fifo_param_if
   import sync_fifo_param_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int CNT_W = clog2(DEPTH + 1);

   logic             flush;
   logic             clr_err;
   logic             wr;
   logic [WIDTH-1:0] wr_data;
   logic             rd;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush, clr_err, wr, wr_data, rd,
      input  rd_data, rd_valid, count, full, empty,
             almost_full, almost_empty, overflow, underflow
   );

   modport slave (
      input  flush, clr_err, wr, wr_data, rd,
      output rd_data, rd_valid, count, full, empty,
             almost_full, almost_empty, overflow, underflow
   );

endinterface

// File: rtl/sync_fifo_param_ram.sv
// ----------------------------------------------------------------------------
// fifo_ram
// WIDTH x DEPTH register array for the synchronous FIFO.
// One synchronous write port, one asynchronous (combinational) read port.
// Contents are intentionally not reset.
// Ports
//   clk    in  1        clock
//   we     in  1        write enable
//   waddr  in  PTR_W    write address
//   wdata  in  WIDTH    write data
//   raddr  in  PTR_W    read address
//   rdata  out WIDTH    mem[raddr]
// ----------------------------------------------------------------------------
module fifo_ram
   import sync_fifo_param_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   localparam int PTR_W = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and a read-valid flag.
// Parameters: WIDTH, DEPTH (power of two, >=2), AF_LEVEL, AE_LEVEL.
// Ports
//   clk   in  clock, everything on posedge
//   rst   in  synchronous active-high reset
//   bus   sync_fifo_param_if.slave (requests in, data/count/flags out)
// Configuration macro
//   SYNC_FIFO_FWFT_EN  undefined : rd_data registered, loaded on each accepted
//                                  read, rd_valid pulses one cycle after it.
//                      defined   : first-word-fall-through, rd_data shows the
//                                  head word, rd_valid = ~empty, rd pops.
// ----------------------------------------------------------------------------
module sync_fifo_param
   import sync_fifo_param_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEF_AF_LEVEL,
   parameter int AE_LEVEL = DEF_AE_LEVEL
) (
   input  logic                   clk,
   input  logic                   rst,
   sync_fifo_param_if.slave       bus
);

   localparam int PTR_W = clog2(DEPTH);
   localparam int CNT_W = clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             overflow_q;
   logic             underflow_q;
   logic             full_c;
   logic             empty_c;
   logic             rd_acc;
   logic             wr_acc;
   logic             ram_we;
   logic [WIDTH-1:0] ram_rdata;

   assign full_c  = (count_q == CNT_W'(DEPTH));
   assign empty_c = (count_q == '0);

   // A write into a full FIFO is still accepted when a read frees a slot in
   // the same cycle; a read from an empty FIFO is never accepted, so a
   // simultaneous write on empty is a plain write.
   assign rd_acc = bus.rd & ~empty_c;
   assign wr_acc = bus.wr & (~full_c | rd_acc);

   // The RAM must not see a write in a cycle that reset or flush overrides.
   assign ram_we = wr_acc & ~rst & ~bus.flush;

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (bus.wr_data),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   // Pointers, occupancy and sticky error flags. Flush empties the FIFO but
   // leaves the error flags alone; a new error wins over clr_err.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);

         if (wr_acc && !rd_acc) begin
            count_q <= count_q + CNT_W'(1);
         end else if (rd_acc && !wr_acc) begin
            count_q <= count_q - CNT_W'(1);
         end

         if (bus.wr && !wr_acc) begin
            overflow_q <= 1'b1;
         end else if (bus.clr_err) begin
            overflow_q <= 1'b0;
         end

         if (bus.rd && !rd_acc) begin
            underflow_q <= 1'b1;
         end else if (bus.clr_err) begin
            underflow_q <= 1'b0;
         end
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   // Head word is always presented; rd merely acknowledges it.
   assign bus.rd_data  = ram_rdata;
   assign bus.rd_valid = ~empty_c;
`else
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q;

   // Registered read port: the popped word appears one cycle after rd is
   // accepted and then holds until the next accepted read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else if (bus.flush) begin
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) rd_data_q <= ram_rdata;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
`endif

   assign bus.count        = count_q;
   assign bus.full         = full_c;
   assign bus.empty        = empty_c;
   assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
   assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_param
// Self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=8, AF=6, AE=2).
// Works in both SYNC_FIFO_FWFT_EN settings. A queue-based model of the FIFO
// tracks contents, sticky flags and the registered read port; directed steps
// cover the boundary cases, followed by a random traffic phase.
// ----------------------------------------------------------------------------
module tb_sync_fifo_param;

   localparam int WIDTH    = 8;
   localparam int DEPTH    = 8;
   localparam int AF_LEVEL = 6;
   localparam int AE_LEVEL = 2;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   sync_fifo_param #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL),
      .AE_LEVEL (AE_LEVEL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [7:0] q [$];
   logic       m_ovf;
   logic       m_unf;
   logic       m_rv;
   logic [7:0] m_rd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      int n;
      n = q.size();
      chk({tag, ".count"},        32'(bus.count),        32'(n));
      chk({tag, ".full"},         32'(bus.full),         32'(n == DEPTH));
      chk({tag, ".empty"},        32'(bus.empty),        32'(n == 0));
      chk({tag, ".almost_full"},  32'(bus.almost_full),  32'(n >= AF_LEVEL));
      chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE_LEVEL));
      chk({tag, ".overflow"},     32'(bus.overflow),     32'(m_ovf));
      chk({tag, ".underflow"},    32'(bus.underflow),    32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
      chk({tag, ".rd_valid"},     32'(bus.rd_valid),     32'(n != 0));
      if (n != 0) chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(q[0]));
`else
      chk({tag, ".rd_valid"},     32'(bus.rd_valid),     32'(m_rv));
      chk({tag, ".rd_data"},      32'(bus.rd_data),      32'(m_rd));
`endif
   endtask

   // Drive one cycle of requests, advance the model by the same rules, wait
   // for the edge and compare everything just after it.
   task automatic applyStimulus(input string tag, input logic r_st, input logic f,
                                input logic c, input logic w, input logic [7:0] d,
                                input logic r);
      logic       racc;
      logic       wacc;
      logic [7:0] popped;
      rst         = r_st;
      bus.flush   = f;
      bus.clr_err = c;
      bus.wr      = w;
      bus.wr_data = d;
      bus.rd      = r;
      if (r_st) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_rv  = 1'b0;
         m_rd  = 8'h00;
      end else if (f) begin
         q.delete();
         m_rv = 1'b0;
      end else begin
         racc = r && (q.size() != 0);
         wacc = w && ((q.size() != DEPTH) || racc);
         popped = 8'h00;
         if (racc) popped = q.pop_front();
         if (wacc) q.push_back(d);
         if (w && !wacc) m_ovf = 1'b1;
         else if (c)     m_ovf = 1'b0;
         if (r && !racc) m_unf = 1'b1;
         else if (c)     m_unf = 1'b0;
         m_rv = racc;
         if (racc) m_rd = popped;
      end
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = 8'h00;
      rst         = 1'b1;
      bus.flush   = 1'b0;
      bus.clr_err = 1'b0;
      bus.wr      = 1'b0;
      bus.wr_data = 8'h00;
      bus.rd      = 1'b0;

      // Reset
      applyStimulus("reset", 1, 0, 0, 0, 8'h00, 0);
      applyStimulus("reset", 1, 0, 0, 0, 8'h00, 0);
      chk("reset_count", 32'(bus.count), 32'd0);
      chk("reset_empty", 32'(bus.empty), 32'd1);
      applyStimulus("idle", 0, 0, 0, 0, 8'h00, 0);

      // Fill 0x01..0x08
      for (int i = 1; i <= 8; i++) begin
         applyStimulus("fill", 0, 0, 0, 1, 8'(i), 0);
         if (i == 5) chk("af_below", 32'(bus.almost_full), 32'd0);
         if (i == 6) chk("af_rise",  32'(bus.almost_full), 32'd1);
      end
      chk("full_at_8", 32'(bus.full), 32'd1);

      // Overflow on full, then clear it
      applyStimulus("ovf", 0, 0, 0, 1, 8'hAA, 0);
      chk("ovf_set",   32'(bus.overflow), 32'd1);
      chk("ovf_count", 32'(bus.count),    32'd8);
      applyStimulus("clr", 0, 0, 1, 0, 8'h00, 0);
      chk("ovf_clr",   32'(bus.overflow), 32'd0);

      // Drain in order
      for (int i = 1; i <= 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         chk("drain_order", 32'(bus.rd_data), 32'(i));
         applyStimulus("drain", 0, 0, 0, 0, 8'h00, 1);
`else
         applyStimulus("drain", 0, 0, 0, 0, 8'h00, 1);
         chk("drain_order", 32'(bus.rd_data), 32'(i));
`endif
      end
      chk("drain_empty", 32'(bus.empty), 32'd1);

      // Underflow on empty
      applyStimulus("unf", 0, 0, 0, 0, 8'h00, 1);
      chk("unf_set",      32'(bus.underflow), 32'd1);
      chk("unf_rd_valid", 32'(bus.rd_valid),  32'd0);
      applyStimulus("clr", 0, 0, 1, 0, 8'h00, 0);

      // rd&wr on empty: write only
      applyStimulus("rw_empty", 0, 0, 0, 1, 8'h55, 1);
      chk("rw_empty_count", 32'(bus.count), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
      chk("rw_empty_data", 32'(bus.rd_data), 32'h55);
      applyStimulus("rd55", 0, 0, 0, 0, 8'h00, 1);
`else
      applyStimulus("rd55", 0, 0, 0, 0, 8'h00, 1);
      chk("rw_empty_data", 32'(bus.rd_data), 32'h55);
`endif

      // Full with rd&wr: count holds, pointers wrap
      for (int i = 0; i < 8; i++) applyStimulus("fill2", 0, 0, 0, 1, 8'(8'h10 + i), 0);
      for (int i = 0; i < 8; i++) applyStimulus("rw_full", 0, 0, 0, 1, 8'h99, 1);
      chk("rw_full_count", 32'(bus.count),    32'd8);
      chk("rw_full_ovf",   32'(bus.overflow), 32'd0);
      for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         chk("rw_full_99", 32'(bus.rd_data), 32'h99);
         applyStimulus("drain99", 0, 0, 0, 0, 8'h00, 1);
`else
         applyStimulus("drain99", 0, 0, 0, 0, 8'h00, 1);
         chk("rw_full_99", 32'(bus.rd_data), 32'h99);
`endif
      end

      // Flush at count 5 keeps sticky flags
      applyStimulus("unf2", 0, 0, 0, 0, 8'h00, 1);
      for (int i = 0; i < 5; i++) applyStimulus("fill5", 0, 0, 0, 1, 8'(8'h20 + i), 0);
      applyStimulus("flush", 0, 1, 0, 1, 8'hEE, 1);
      chk("flush_count", 32'(bus.count),     32'd0);
      chk("flush_unf",   32'(bus.underflow), 32'd1);
      applyStimulus("post_flush_wr", 0, 0, 0, 1, 8'h3C, 0);
      applyStimulus("post_flush_rd", 0, 0, 0, 0, 8'h00, 1);
`ifndef SYNC_FIFO_FWFT_EN
      chk("post_flush_data", 32'(bus.rd_data), 32'h3C);
`endif

      // Reset in the middle of rd&wr traffic
      for (int i = 0; i < 4; i++) applyStimulus("pre", 0, 0, 0, 1, 8'(8'h40 + i), 0);
      for (int i = 0; i < 5; i++) applyStimulus("traffic", 0, 0, 0, 1, 8'(8'h50 + i), 1);
      applyStimulus("mid_rst", 1, 0, 0, 1, 8'h77, 1);
      chk("mid_rst_count", 32'(bus.count), 32'd0);
      chk("mid_rst_empty", 32'(bus.empty), 32'd1);
      for (int i = 0; i < 6; i++) applyStimulus("resume", 0, 0, 0, 1, 8'(8'h60 + i), (i > 1));

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         logic       r_st;
         logic       f;
         logic       c;
         logic       w;
         logic       r;
         logic [7:0] d;
         r_st = ($urandom_range(0, 149) == 0);
         f    = ($urandom_range(0, 59) == 0);
         c    = ($urandom_range(0, 19) == 0);
         w    = ($urandom_range(0, 3) < ((i % 200) < 100 ? 3 : 1));
         r    = ($urandom_range(0, 3) < ((i % 200) < 100 ? 1 : 3));
         d    = 8'($urandom);
         applyStimulus("rand", r_st, f, c, w, d, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
